// File: rtl/dii_packetizer_if.sv
// DII channel: one word per valid/ready handshake, framed by first/last.
interface dii_channel #(
  parameter int WIDTH = 16
);
  logic             valid;
  logic             first;
  logic             last;
  logic [WIDTH-1:0] data;
  logic             ready;

  modport master (output valid, output first, output last, output data, input ready);
  modport slave  (input valid, input first, input last, input data, output ready);
endinterface

// File: rtl/dii_packetizer.sv
// Captures one event (3 header words + up to MAX_PAYLOAD payload words) and
// serialises it as a single first/last framed DII packet under ready backpressure.
module dii_packetizer #(
  parameter int WIDTH       = 16,
  parameter int MAX_PAYLOAD = 8,
  localparam int LEN_W      = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             hdr_dest,
  input  logic [WIDTH-1:0]             hdr_src,
  input  logic [WIDTH-1:0]             hdr_flags,
  input  logic [MAX_PAYLOAD*WIDTH-1:0] payload,
  input  logic [LEN_W-1:0]             payload_len,
  input  logic                         event_valid,
  output logic                         event_ready,
  output logic [15:0]                  packet_count,
  dii_channel.master                   out
);

  localparam int IDX_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR0 = 3'd1;
  localparam logic [2:0] S_HDR1 = 3'd2;
  localparam logic [2:0] S_HDR2 = 3'd3;
  localparam logic [2:0] S_PAY  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] dest_q, dest_d;
  logic [WIDTH-1:0] src_q, src_d;
  logic [WIDTH-1:0] flags_q, flags_d;
  logic [WIDTH-1:0] payload_q [MAX_PAYLOAD];
  logic [WIDTH-1:0] payload_d [MAX_PAYLOAD];
  logic [WIDTH-1:0] payload_word [MAX_PAYLOAD];
  logic [LEN_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      packet_count_q, packet_count_d;

  logic             out_valid;
  logic             out_first;
  logic             out_last;
  logic [WIDTH-1:0] out_data;
  logic             handshake;
  logic             pay_last;
  logic             capture;
  logic [LEN_W-1:0] len_clamped;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_PAYLOAD; gi++) begin : g_payload_word
      assign payload_word[gi] = payload[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign len_clamped = (payload_len > LEN_W'(MAX_PAYLOAD)) ? LEN_W'(MAX_PAYLOAD) : payload_len;
  assign pay_last    = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));
  assign capture     = (state_q == S_IDLE) && event_valid;
  assign handshake   = out_valid && out.ready;

  // Outputs depend only on registered state, so inputs never reach out.* combinationally.
  always_comb begin
    out_valid = (state_q != S_IDLE);
    out_first = (state_q == S_HDR0);
    out_last  = 1'b0;
    out_data  = '0;
    case (state_q)
      S_HDR0: out_data = dest_q;
      S_HDR1: out_data = src_q;
      S_HDR2: begin
        out_data = flags_q;
        out_last = (len_q == '0);
      end
      S_PAY: begin
        out_data = payload_q[idx_q];
        out_last = pay_last;
      end
      default: out_data = '0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    dest_d         = dest_q;
    src_d          = src_q;
    flags_d        = flags_q;
    payload_d      = payload_q;
    len_d          = len_q;
    idx_d          = idx_q;
    packet_count_d = packet_count_q;
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          dest_d    = hdr_dest;
          src_d     = hdr_src;
          flags_d   = hdr_flags;
          payload_d = payload_word;
          len_d     = len_clamped;
          idx_d     = '0;
          state_d   = S_HDR0;
        end
      end
      S_HDR0: if (handshake) state_d = S_HDR1;
      S_HDR1: if (handshake) state_d = S_HDR2;
      S_HDR2: begin
        if (handshake) begin
          if (len_q == '0) begin
            state_d        = S_IDLE;
            packet_count_d = packet_count_q + 16'd1;
          end else begin
            state_d = S_PAY;
            idx_d   = '0;
          end
        end
      end
      S_PAY: begin
        if (handshake) begin
          if (pay_last) begin
            state_d        = S_IDLE;
            packet_count_d = packet_count_q + 16'd1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      dest_q         <= '0;
      src_q          <= '0;
      flags_q        <= '0;
      len_q          <= '0;
      idx_q          <= '0;
      packet_count_q <= '0;
      for (int i = 0; i < MAX_PAYLOAD; i++) payload_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      dest_q         <= dest_d;
      src_q          <= src_d;
      flags_q        <= flags_d;
      len_q          <= len_d;
      idx_q          <= idx_d;
      packet_count_q <= packet_count_d;
      payload_q      <= payload_d;
    end
  end

  assign event_ready  = (state_q == S_IDLE);
  assign packet_count = packet_count_q;
  assign out.valid    = out_valid;
  assign out.first    = out_first;
  assign out.last     = out_last;
  assign out.data     = out_data;

endmodule

// File: tb/tb_dii_packetizer.sv
// Randomised scoreboard bench: the stimulus pushes each captured event's wire image,
// a negedge monitor pops and compares every handshaken word.
module tb_dii_packetizer;

  localparam int W    = 16;
  localparam int MAXP = 8;
  localparam int LW   = $clog2(MAXP + 1);

  typedef struct packed {
    logic         first;
    logic         last;
    logic [W-1:0] data;
  } word_t;

  logic              clk;
  logic              rst_n;
  logic [W-1:0]      hdr_dest, hdr_src, hdr_flags;
  logic [MAXP*W-1:0] payload;
  logic [LW-1:0]     payload_len;
  logic              event_valid;
  logic              event_ready;
  logic [15:0]       packet_count;

  dii_channel #(.WIDTH(W)) ch ();

  dii_packetizer #(.WIDTH(W), .MAX_PAYLOAD(MAXP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hdr_dest     (hdr_dest),
    .hdr_src      (hdr_src),
    .hdr_flags    (hdr_flags),
    .payload      (payload),
    .payload_len  (payload_len),
    .event_valid  (event_valid),
    .event_ready  (event_ready),
    .packet_count (packet_count),
    .out          (ch)
  );

  int    checks = 0;
  int    passes = 0;
  word_t exp_q[$];
  logic [15:0] model_count = 16'd0;
  int    ready_mode = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Wire image of one event: three header words then min(len, MAXP) payload words.
  function automatic void push_expected(logic [W-1:0] d, logic [W-1:0] s, logic [W-1:0] f,
                                        logic [MAXP*W-1:0] p, logic [LW-1:0] l);
    int n;
    n = (int'(l) > MAXP) ? MAXP : int'(l);
    exp_q.push_back('{first: 1'b1, last: 1'b0, data: d});
    exp_q.push_back('{first: 1'b0, last: 1'b0, data: s});
    exp_q.push_back('{first: 1'b0, last: (n == 0), data: f});
    for (int i = 0; i < n; i++)
      exp_q.push_back('{first: 1'b0, last: (i == n - 1), data: p[i*W +: W]});
  endfunction

  // Ready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
  initial begin
    int cyc;
    cyc = 0;
    ch.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       ch.ready = (cyc % 3 == 0);
        2:       ch.ready = 1'($urandom_range(0, 1));
        default: ch.ready = 1'b1;
      endcase
      cyc++;
    end
  end

  // Monitor / scoreboard.
  initial begin
    word_t e;
    logic  stall_hold;
    logic [W+1:0] stall_word;
    stall_hold = 1'b0;
    stall_word = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        model_count = 16'd0;
        stall_hold  = 1'b0;
      end else begin
        chk("event_ready", 32'(event_ready), 32'(exp_q.size() == 0));
        chk("out_valid", 32'(ch.valid), 32'(exp_q.size() != 0));
        chk("packet_count", 32'(packet_count), 32'(model_count));
        if (stall_hold && ch.valid)
          chk("stall_hold", 32'({ch.first, ch.last, ch.data}), 32'(stall_word));
        stall_hold = ch.valid && !ch.ready;
        stall_word = {ch.first, ch.last, ch.data};
        if (ch.valid && ch.ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL extra_word: got %0h expected none", ch.data);
          end else begin
            e = exp_q.pop_front();
            chk("word", 32'({ch.first, ch.last, ch.data}), 32'({e.first, e.last, e.data}));
            if (e.last) model_count = model_count + 16'd1;
          end
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] d, input logic [W-1:0] s, input logic [W-1:0] f,
                       input logic [MAXP*W-1:0] p, input logic [LW-1:0] l, input bit keep);
    bit got;
    hdr_dest    = d;
    hdr_src     = s;
    hdr_flags   = f;
    payload     = p;
    payload_len = l;
    event_valid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (event_ready) got = 1'b1;
    end
    if (!got) begin
      checks++;
      $display("FAIL event_handshake: got no event_ready expected within 300 cycles");
    end
    @(posedge clk);
    if (got) push_expected(d, s, f, p, l);
    $display("event dest=%04h src=%04h flags=%04h len=%0d ready_mode=%0d", d, s, f, l, ready_mode);
    #1;
    if (!keep) event_valid = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 500) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MAXP*W-1:0] rand_payload();
    logic [MAXP*W-1:0] p;
    for (int i = 0; i < MAXP; i++) p[i*W +: W] = W'($urandom);
    return p;
  endfunction

  initial begin
    logic [MAXP*W-1:0] p;
    rst_n       = 1'b1;
    hdr_dest    = '0;
    hdr_src     = '0;
    hdr_flags   = '0;
    payload     = '0;
    payload_len = '0;
    event_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_valid", 32'(ch.valid), 32'd0);
    chk("reset_first_last", 32'({ch.first, ch.last}), 32'd0);
    chk("reset_data", 32'(ch.data), 32'd0);
    chk("reset_event_ready", 32'(event_ready), 32'd1);
    chk("reset_count", 32'(packet_count), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two-word payload, always ready.
    p = '0;
    p[0*W +: W] = 16'hAAAA;
    p[1*W +: W] = 16'hBBBB;
    issue(16'h0001, 16'h0010, 16'h8000, p, LW'(2), 1'b0);
    drain();

    // Header-only packet.
    issue(16'h0002, 16'h0020, 16'h8000, rand_payload(), LW'(0), 1'b0);
    drain();

    // Asynchronous reset while the src word is on the wire.
    issue(16'h0003, 16'h0030, 16'h4000, rand_payload(), LW'(4), 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midpkt_reset_valid", 32'(ch.valid), 32'd0);
    chk("midpkt_reset_event_ready", 32'(event_ready), 32'd1);
    chk("midpkt_reset_count", 32'(packet_count), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Backpressure with ready 1,0,0 repeating.
    ready_mode = 1;
    issue(16'h1234, 16'h5678, 16'h9ABC, rand_payload(), LW'(3), 1'b0);
    drain();
    ready_mode = 0;

    // Oversized length is clamped to MAXP.
    issue(16'h00F0, 16'h00F1, 16'h00F2, rand_payload(), LW'(15), 1'b0);
    drain();

    // Back-to-back events with event_valid held.
    issue(16'hA001, 16'hA002, 16'hA003, rand_payload(), LW'(1), 1'b1);
    issue(16'hB001, 16'hB002, 16'hB003, rand_payload(), LW'(2), 1'b0);
    drain();

    // Randomised traffic.
    for (int n = 0; n < 40; n++) begin
      ready_mode = int'($urandom_range(0, 2));
      issue(W'($urandom), W'($urandom), W'($urandom), rand_payload(),
            LW'($urandom_range(0, 15)), (n != 39) && ($urandom_range(0, 1) == 1));
    end
    ready_mode = 2;
    drain();
    ready_mode = 0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
